// File: rtl/x_mem_responder_if.sv
// Core memory bus between an initiator (master) and the RAM responder (slave).
// Request signals flow master->slave; accept, data, err and busy flow back.
interface x_mem_responder_if;
  logic        i_valid;
  logic        i_rnw;
  logic [31:0] i_addr;
  logic [31:0] i_data;
  logic        o_accept;
  logic [31:0] o_data;
  logic        o_err;
  logic        o_busy;

  modport master (
    output i_valid, i_rnw, i_addr, i_data,
    input  o_accept, o_data, o_err, o_busy
  );

  modport slave (
    input  i_valid, i_rnw, i_addr, i_data,
    output o_accept, o_data, o_err, o_busy
  );
endinterface

// File: rtl/x_mem_responder.sv
// Word-organised RAM responder with fixed wait-state latency and a
// side-band preload port that wins over bus writes on collision.
module x_mem_responder #(
  parameter int AW      = 10,
  parameter int LATENCY = 2
) (
  input  logic          i_clk,
  input  logic          i_rst,
  x_mem_responder_if.slave bus,
  input  logic          i_ld_en,
  input  logic [AW-1:0] i_ld_addr,
  input  logic [31:0]   i_ld_data
);

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    RESP
  } state_t;

  localparam logic [3:0] LAT_M1 = 4'(LATENCY - 1);

  state_t      r_state;
  state_t      w_next;
  logic [3:0]  r_cnt;
  logic [3:0]  w_cnt_next;
  logic        r_rnw;
  logic [AW-1:0] r_idx;
  logic        r_oor;
  logic [31:0] r_wdata;
  logic [31:0] r_data;
  logic [31:0] r_mem [2**AW];

  logic          w_req;
  logic [AW-1:0] w_in_idx;
  logic          w_in_oor;
  logic [AW-1:0] w_rd_idx;
  logic          w_rd_oor;
  logic          w_enter_resp;
  logic          w_bus_wr;

  assign w_req    = (r_state == IDLE) && bus.i_valid;
  assign w_in_idx = bus.i_addr[AW+1:2];
  assign w_in_oor = |bus.i_addr[31:AW+2];

  // With LATENCY=1 RESP is entered straight from IDLE, before the latch.
  assign w_rd_idx = (r_state == IDLE) ? w_in_idx : r_idx;
  assign w_rd_oor = (r_state == IDLE) ? w_in_oor : r_oor;

  assign w_enter_resp = (r_state != RESP) && (w_next == RESP);
  assign w_bus_wr     = (r_state == RESP) && !r_rnw && !r_oor;

  always_comb begin
    w_next     = r_state;
    w_cnt_next = r_cnt;
    unique case (r_state)
      IDLE: begin
        if (bus.i_valid) begin
          w_cnt_next = LAT_M1;
          w_next     = (LATENCY == 1) ? RESP : WAIT;
        end
      end
      WAIT: begin
        if (r_cnt <= 4'd1) begin
          w_next = RESP;
        end else begin
          w_cnt_next = r_cnt - 4'd1;
        end
      end
      RESP: w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state <= IDLE;
      r_cnt   <= '0;
      r_rnw   <= 1'b0;
      r_idx   <= '0;
      r_oor   <= 1'b0;
      r_wdata <= '0;
      r_data  <= '0;
    end else begin
      r_state <= w_next;
      r_cnt   <= w_cnt_next;
      if (w_req) begin
        r_rnw   <= bus.i_rnw;
        r_idx   <= w_in_idx;
        r_oor   <= w_in_oor;
        r_wdata <= bus.i_data;
      end
      if (w_enter_resp) begin
        r_data <= w_rd_oor ? 32'd0 : r_mem[w_rd_idx];
      end else if (w_next != RESP) begin
        r_data <= '0;
      end
    end
  end

  // Load port is written last so it overrides a bus write to the same word.
  always_ff @(posedge i_clk) begin
    if (w_bus_wr && !i_rst) begin
      r_mem[r_idx] <= r_wdata;
    end
    if (i_ld_en) begin
      r_mem[i_ld_addr] <= i_ld_data;
    end
  end

  assign bus.o_accept = (r_state == RESP);
  assign bus.o_err    = (r_state == RESP) && r_oor;
  assign bus.o_busy   = (r_state != IDLE);
  assign bus.o_data   = r_data;

endmodule

// File: tb/tb_x_mem_responder.sv
// Self-checking bench for x_mem_responder: scoreboard of expected
// responses popped on every accept pulse, plus per-scenario checks.
module tb_x_mem_responder;

  localparam int AW  = 10;
  localparam int LAT = 2;

  typedef struct {
    logic        rnw;
    logic [31:0] data;
    logic        err;
    string       nm;
  } exp_t;

  logic          clk = 1'b0;
  logic          rst;
  logic          ld_en;
  logic [AW-1:0] ld_addr;
  logic [31:0]   ld_data;

  int n_chk  = 0;
  int n_fail = 0;
  int n_acc  = 0;
  int cyc    = 0;
  exp_t q[$];

  x_mem_responder_if bus ();

  x_mem_responder #(
    .AW(AW),
    .LATENCY(LAT)
  ) dut (
    .i_clk(clk),
    .i_rst(rst),
    .bus(bus.slave),
    .i_ld_en(ld_en),
    .i_ld_addr(ld_addr),
    .i_ld_data(ld_data)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Scoreboard: each accept pops the oldest expectation.
  always @(negedge clk) begin
    if (!rst && bus.o_accept) begin
      exp_t e;
      n_acc = n_acc + 1;
      n_chk = n_chk + 1;
      if (q.size() == 0) begin
        n_fail = n_fail + 1;
        $display("FAIL unexpected_accept: got accept, wanted none");
      end else begin
        e = q.pop_front();
        if (bus.o_err !== e.err) begin
          n_fail = n_fail + 1;
          $display("FAIL %s_err: got %b wanted %b", e.nm, bus.o_err, e.err);
        end
        if (e.rnw) begin
          n_chk = n_chk + 1;
          if (bus.o_data !== e.data) begin
            n_fail = n_fail + 1;
            $display("FAIL %s_data: got %h wanted %h",
                     e.nm, bus.o_data, e.data);
          end
        end
      end
    end else if (!rst && bus.o_data !== 32'd0) begin
      n_chk = n_chk + 1;
      n_fail = n_fail + 1;
      $display("FAIL data_idle: got %h wanted 0", bus.o_data);
    end
  end

  task automatic load(input logic [AW-1:0] a, input logic [31:0] d);
    @(posedge clk); #1;
    ld_en = 1'b1; ld_addr = a; ld_data = d;
    @(posedge clk); #1;
    ld_en = 1'b0;
  endtask

  task automatic bus_op(input logic rnw, input logic [31:0] a, d,
                        input logic [31:0] exp_d, input logic exp_e,
                        input string nm);
    int n;
    q.push_back('{rnw: rnw, data: exp_d, err: exp_e, nm: nm});
    @(posedge clk); #1;
    bus.i_valid = 1'b1; bus.i_rnw = rnw;
    bus.i_addr = a; bus.i_data = d;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!bus.o_accept && n < 50);
    n_chk++;
    if (n !== LAT + 1) begin
      n_fail++;
      $display("FAIL %s_latency: got %0d wanted %0d", nm, n, LAT + 1);
    end
    @(posedge clk); #1;
    bus.i_valid = 1'b0;
  endtask

  task automatic test_reset;
    rst = 1'b1;
    bus.i_valid = 1'b0; bus.i_rnw = 1'b1;
    bus.i_addr = '0; bus.i_data = '0;
    ld_en = 1'b0; ld_addr = '0; ld_data = '0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    n_chk++;
    if ({bus.o_accept, bus.o_err, bus.o_busy} !== 3'b000 ||
        bus.o_data !== 32'd0) begin
      n_fail++;
      $display("FAIL reset_outputs: got acc=%b err=%b busy=%b data=%h wanted 0",
               bus.o_accept, bus.o_err, bus.o_busy, bus.o_data);
    end
  endtask

  task automatic test_preload;
    load(10'd0, 32'h00500093);
    load(10'd1, 32'h11110001);
    load(10'd2, 32'h22220002);
    load(10'd8, 32'h0BADF00D);
    bus_op(1'b1, 32'h0, 32'h0, 32'h00500093, 1'b0, "preload_rd");
  endtask

  task automatic test_write_read;
    bus_op(1'b0, 32'h10, 32'hDEADBEEF, 32'h0, 1'b0, "wr_10");
    bus_op(1'b1, 32'h13, 32'h0, 32'hDEADBEEF, 1'b0, "rd_13");
  endtask

  task automatic test_out_of_range;
    bus_op(1'b0, 32'h1000, 32'h12345678, 32'h0, 1'b1, "oor_wr");
    bus_op(1'b1, 32'h1000, 32'h0, 32'h0, 1'b1, "oor_rd");
    bus_op(1'b1, 32'h0, 32'h0, 32'h00500093, 1'b0, "oor_unchanged");
  endtask

  task automatic test_back_to_back;
    logic [31:0] addrs [3];
    logic [31:0] datas [3];
    int t [3];
    int k;
    int n;
    addrs[0] = 32'h0; addrs[1] = 32'h4; addrs[2] = 32'h8;
    datas[0] = 32'h00500093; datas[1] = 32'h11110001;
    datas[2] = 32'h22220002;
    for (int i = 0; i < 3; i++)
      q.push_back('{rnw: 1'b1, data: datas[i], err: 1'b0, nm: "b2b"});
    @(posedge clk); #1;
    bus.i_valid = 1'b1; bus.i_rnw = 1'b1; bus.i_addr = addrs[0];
    k = 0; n = 0;
    while (k < 3 && n < 60) begin
      @(negedge clk);
      n++;
      if (bus.o_accept) begin
        t[k] = n;
        k++;
        @(posedge clk); #1;
        if (k < 3) bus.i_addr = addrs[k];
        else bus.i_valid = 1'b0;
      end
    end
    bus.i_valid = 1'b0;
    n_chk++;
    if (k !== 3) begin
      n_fail++;
      $display("FAIL b2b_count: got %0d accepts wanted 3", k);
    end else begin
      for (int i = 1; i < 3; i++) begin
        n_chk++;
        if (t[i] - t[i-1] !== LAT + 1) begin
          n_fail++;
          $display("FAIL b2b_spacing%0d: got %0d wanted %0d",
                   i, t[i] - t[i-1], LAT + 1);
        end
      end
    end
  endtask

  task automatic test_reset_midop;
    int acc0;
    acc0 = n_acc;
    @(posedge clk); #1;
    bus.i_valid = 1'b1; bus.i_rnw = 1'b0;
    bus.i_addr = 32'h20; bus.i_data = 32'hAAAA5555;
    @(posedge clk); #1;
    bus.i_valid = 1'b0;
    @(negedge clk);
    n_chk++;
    if (bus.o_busy !== 1'b1) begin
      n_fail++;
      $display("FAIL midop_busy_wait: got %b wanted 1", bus.o_busy);
    end
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    n_chk++;
    if (bus.o_busy !== 1'b0 || bus.o_accept !== 1'b0) begin
      n_fail++;
      $display("FAIL midop_idle: got busy=%b acc=%b wanted 0 0",
               bus.o_busy, bus.o_accept);
    end
    repeat (4) @(negedge clk);
    n_chk++;
    if (n_acc !== acc0) begin
      n_fail++;
      $display("FAIL midop_no_accept: got %0d accepts wanted 0",
               n_acc - acc0);
    end
    bus_op(1'b1, 32'h20, 32'h0, 32'h0BADF00D, 1'b0, "midop_old");
  endtask

  task automatic test_collision;
    int n;
    q.push_back('{rnw: 1'b0, data: 32'h0, err: 1'b0, nm: "coll_wr"});
    @(posedge clk); #1;
    bus.i_valid = 1'b1; bus.i_rnw = 1'b0;
    bus.i_addr = 32'h40; bus.i_data = 32'h11111111;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!bus.o_accept && n < 50);
    n_chk++;
    if (!bus.o_accept) begin
      n_fail++;
      $display("FAIL coll_timeout: got no accept wanted accept");
    end
    ld_en = 1'b1; ld_addr = 10'h10; ld_data = 32'h22222222;
    @(posedge clk); #1;
    ld_en = 1'b0; bus.i_valid = 1'b0;
    bus_op(1'b1, 32'h40, 32'h0, 32'h22222222, 1'b0, "coll_rd");
  endtask

  initial begin
    test_reset();
    test_preload();
    test_write_read();
    test_out_of_range();
    test_back_to_back();
    test_reset_midop();
    test_collision();
    repeat (3) @(negedge clk);
    n_chk++;
    if (q.size() !== 0) begin
      n_fail++;
      $display("FAIL scoreboard_drain: got %0d pending wanted 0", q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got timeout wanted completion");
    $fatal(1);
  end

endmodule
